calcium_update_scheduler: RTL and testbench

//  Sequences per-neuron calcium/leak state updates through the neuron-state SRAM for the AD calcium model datapath.
//  Two requesters share the single datapath and SRAM port:
//   - a time-reference sweep, which leak-updates every neuron;
//   - single-neuron spike updates from the core controller.

---
 rtl/calcium_update_scheduler.sv | 146 ++++++++++++++
 tb/tb_calcium_update_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calcium_update_scheduler.sv
// calcium_update_scheduler
//   Sequences per-neuron calcium/leak updates through the single neuron-state
//   SRAM port. Two requesters share the datapath: a time-reference sweep that
//   leak-updates neurons 0..N_NEURON-1, and single-neuron spike updates from
//   the core controller. Each op is READ -> LATCH -> WRITE (3 cycles), and
//   back-to-back ops chain WRITE -> READ with no idle cycle. When both
//   requesters are pending, they are served round-robin.
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   param_ca_en              gates new sweep_req only
//   sweep_req                1-cycle time-reference pulse
//   spk_req / spk_addr       spike request (held until spk_ack) and its neuron
//   spk_ack                  pulse in the WRITE cycle of a spike op
//   busy                     FSM active or a sweep still pending
//   sweep_done               pulse one cycle after the last sweep write
//   sweep_overrun            sticky: sweep_req arrived while a sweep was active
//   sram_*                   SRAM port; word = {cnt, ca}; rdata is one cycle late
//   dp_calcium/dp_caleak_cnt registered word fields fed to the datapath
//   dp_event_tref/dp_spike   op-type strobes during the WRITE cycle
//   dp_*_next                combinational datapath results
module calcium_update_scheduler #(
  parameter int N_NEURON = 256,
  parameter int ADDR_W   = 8,
  parameter int CA_W     = 3,
  parameter int CNT_W    = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    param_ca_en,
  input  logic                    sweep_req,
  input  logic                    spk_req,
  input  logic [ADDR_W-1:0]       spk_addr,
  output logic                    spk_ack,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    sweep_overrun,
  output logic                    sram_cs,
  output logic                    sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [CA_W+CNT_W-1:0]   sram_wdata,
  input  logic [CA_W+CNT_W-1:0]   sram_rdata,
  output logic [CA_W-1:0]         dp_calcium,
  output logic [CNT_W-1:0]        dp_caleak_cnt,
  output logic                    dp_event_tref,
  output logic                    dp_spike,
  input  logic [CA_W-1:0]         dp_calcium_next,
  input  logic [CNT_W-1:0]        dp_caleak_cnt_next
);

  localparam int W = CA_W + CNT_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_NEURON - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LATCH, S_WRITE} state_t;

  state_t              state, state_nx;
  logic                op_spk;      // current op is a spike op
  logic                last_spk;    // last grant went to the spike requester
  logic                sweep_pend;
  logic [ADDR_W-1:0]   sweep_ptr;
  logic [ADDR_W-1:0]   spk_addr_q;  // spike address captured at grant
  logic [ADDR_W-1:0]   op_addr;

  logic last_sweep_op, sweep_avail, spk_avail, arb_pt, grant, grant_spk;

  // The op finishing in this WRITE must not be granted again: the last sweep
  // op clears sweep_pend at this edge, and a spike op is being acked now
  // while its requester still holds spk_req.
  assign last_sweep_op = (state == S_WRITE) && !op_spk && (sweep_ptr == LAST_PTR);
  assign sweep_avail   = sweep_pend && !last_sweep_op;
  assign spk_avail     = spk_req && !((state == S_WRITE) && op_spk);
  assign arb_pt        = (state == S_IDLE) || (state == S_WRITE);
  assign grant         = arb_pt && (sweep_avail || spk_avail);
  assign grant_spk     = spk_avail && (!sweep_avail || !last_spk);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant) state_nx = S_READ;
      S_READ:  state_nx = S_LATCH;
      S_LATCH: state_nx = S_WRITE;
      S_WRITE: state_nx = grant ? S_READ : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign op_addr       = op_spk ? spk_addr_q : sweep_ptr;
  assign sram_cs       = (state == S_READ) || (state == S_WRITE);
  assign sram_we       = (state == S_WRITE);
  assign sram_addr     = sram_cs ? op_addr : '0;
  assign sram_wdata    = sram_we ? {dp_caleak_cnt_next, dp_calcium_next} : '0;
  assign dp_event_tref = sram_we && !op_spk;
  assign dp_spike      = sram_we && op_spk;
  assign spk_ack       = dp_spike;
  assign busy          = (state != S_IDLE) || sweep_pend;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= S_IDLE;
      op_spk        <= 1'b0;
      last_spk      <= 1'b1;
      sweep_pend    <= 1'b0;
      sweep_ptr     <= '0;
      spk_addr_q    <= '0;
      sweep_done    <= 1'b0;
      sweep_overrun <= 1'b0;
      dp_calcium    <= '0;
      dp_caleak_cnt <= '0;
    end else begin
      state      <= state_nx;
      sweep_done <= 1'b0;

      if (grant) begin
        op_spk   <= grant_spk;
        last_spk <= grant_spk;
        if (grant_spk) spk_addr_q <= spk_addr;
      end

      if (state == S_LATCH) begin
        dp_calcium    <= sram_rdata[CA_W-1:0];
        dp_caleak_cnt <= sram_rdata[W-1:CA_W];
      end

      if ((state == S_WRITE) && !op_spk) begin
        if (sweep_ptr == LAST_PTR) begin
          sweep_ptr  <= '0;
          sweep_pend <= 1'b0;
          sweep_done <= 1'b1;
        end else begin
          sweep_ptr <= sweep_ptr + ADDR_W'(1);
        end
      end

      // sweep_pend stays set through the final WRITE, so a request landing
      // there counts as an overrun rather than starting a new sweep.
      if (sweep_req && param_ca_en) begin
        if (!sweep_pend) begin
          sweep_pend <= 1'b1;
          sweep_ptr  <= '0;
        end else begin
          sweep_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_calcium_update_scheduler.sv
module tb_calcium_update_scheduler;
  localparam int N = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       param_ca_en = 1'b0, sweep_req = 1'b0, spk_req = 1'b0;
  logic [7:0] spk_addr = '0;
  logic       spk_ack, busy, sweep_done, sweep_overrun, sram_cs, sram_we;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;
  logic [2:0] dp_calcium, dp_ca_n;
  logic [4:0] dp_caleak_cnt, dp_cnt_n;
  logic       dp_event_tref, dp_spike;

  calcium_update_scheduler #(.N_NEURON(N), .ADDR_W(8), .CA_W(3), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .param_ca_en(param_ca_en), .sweep_req(sweep_req),
    .spk_req(spk_req), .spk_addr(spk_addr), .spk_ack(spk_ack), .busy(busy),
    .sweep_done(sweep_done), .sweep_overrun(sweep_overrun), .sram_cs(sram_cs),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .dp_calcium(dp_calcium), .dp_caleak_cnt(dp_caleak_cnt),
    .dp_event_tref(dp_event_tref), .dp_spike(dp_spike),
    .dp_calcium_next(dp_ca_n), .dp_caleak_cnt_next(dp_cnt_n)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // datapath stand-in: fixed result, or ca+1 / cnt+3 per update
  logic fixed_dp = 1'b0;
  always_comb begin
    dp_ca_n  = 3'd3;
    dp_cnt_n = 5'd4;
    if (!fixed_dp) begin
      dp_ca_n  = dp_calcium + 3'd1;
      dp_cnt_n = dp_caleak_cnt + 5'd3;
    end
  end

  // SRAM model with a preload port for the bench
  logic [7:0] mem [0:255];
  logic       load_en = 1'b0;
  logic [7:0] load_addr = '0, load_data = '0;
  always @(posedge CLK) begin
    if (load_en) mem[load_addr] <= load_data;
    else begin
      if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
      if (sram_cs && sram_we)  mem[sram_addr] <= sram_wdata;
    end
  end

  // write/done monitor
  int wl_addr[$], wl_spk[$], wl_tref[$], wl_cyc[$], done_cyc[$];
  int access_cnt = 0;
  always @(negedge CLK) begin
    if (sram_cs && sram_we) begin
      wl_addr.push_back(int'(sram_addr));
      wl_spk.push_back(int'(dp_spike));
      wl_tref.push_back(int'(dp_event_tref));
      wl_cyc.push_back(cyc);
    end
    if (sweep_done) done_cyc.push_back(cyc);
    if (sram_cs) access_cnt <= access_cnt + 1;
  end

  logic [31:0] all_outs;
  assign all_outs = {spk_ack, busy, sweep_done, sweep_overrun, sram_cs, sram_we, sram_addr,
                     sram_wdata, dp_calcium, dp_caleak_cnt, dp_event_tref, dp_spike};

  int n_cmp = 0, n_bad = 0;

  // expected word after k updates of ca+1 / cnt+3
  function automatic logic [7:0] upd(input logic [7:0] w, input int k);
    logic [2:0] ca;
    logic [4:0] cnt;
    ca  = w[2:0] + 3'(k);
    cnt = w[7:3] + 5'(3 * k);
    return {cnt, ca};
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic load(input int a, input logic [7:0] d);
    load_en = 1'b1; load_addr = 8'(a); load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_sweep();
    sweep_req = 1'b1;
    tick();
    sweep_req = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    n_cmp++;
    if (all_outs !== 32'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 00000000", all_outs); end
    RST = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({busy, sram_cs} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: busy/cs got %b want 00", {busy, sram_cs}); end
  endtask

  task automatic test_spike_latency();
    fixed_dp = 1'b1;
    load(5, 8'h1A);
    spk_addr = 8'h05; spk_req = 1'b1;               // cycle 0
    n_cmp++;
    if (sram_cs !== 1'b0) begin n_bad++; $display("FAIL lat_c0_cs: got %b want 0", sram_cs); end
    tick();                                          // cycle 1: READ
    n_cmp++;
    if ({sram_cs, sram_we, sram_addr} !== {1'b1, 1'b0, 8'h05}) begin
      n_bad++; $display("FAIL lat_c1_read: got %b%b %h want 10 05", sram_cs, sram_we, sram_addr);
    end
    tick();                                          // cycle 2: LATCH
    n_cmp++;
    if (sram_cs !== 1'b0) begin n_bad++; $display("FAIL lat_c2_cs: got %b want 0", sram_cs); end
    tick();                                          // cycle 3: WRITE
    n_cmp++;
    if ({sram_cs, sram_we, sram_addr, sram_wdata, spk_ack, dp_spike, dp_event_tref} !==
        {1'b1, 1'b1, 8'h05, 8'h23, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL lat_c3_write: cs%b we%b a%h wd%h ack%b spk%b tref%b want cs1 we1 a05 wd23 ack1 spk1 tref0",
                        sram_cs, sram_we, sram_addr, sram_wdata, spk_ack, dp_spike, dp_event_tref);
    end
    n_cmp++;
    if ({dp_calcium, dp_caleak_cnt} !== {3'd2, 5'd3}) begin
      n_bad++; $display("FAIL lat_latched: ca %0d cnt %0d want 2 3", dp_calcium, dp_caleak_cnt);
    end
    spk_req = 1'b0;
    tick();
    n_cmp++;
    if ({spk_ack, busy, sram_cs} !== 3'b000) begin n_bad++; $display("FAIL lat_after: ack/busy/cs %b want 000", {spk_ack, busy, sram_cs}); end
    n_cmp++;
    if (mem[5] !== 8'h23) begin n_bad++; $display("FAIL lat_mem: got %h want 23", mem[5]); end
    fixed_dp = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] init [N];
    int s, d0;
    for (int a = 0; a < N; a++) begin init[a] = 8'($urandom); load(a, init[a]); end
    s = wl_addr.size(); d0 = done_cyc.size();
    param_ca_en = 1'b1;
    pulse_sweep();
    repeat (25) tick();
    n_cmp++;
    if (wl_addr.size() - s != N) begin
      n_bad++; $display("FAIL sweep_nwrites: got %0d want %0d", wl_addr.size() - s, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (wl_addr[s+i] != i || wl_tref[s+i] != 1 || wl_spk[s+i] != 0) begin
          n_bad++; $display("FAIL sweep_op%0d: addr %0d tref %0d spk %0d want addr %0d tref 1 spk 0",
                            i, wl_addr[s+i], wl_tref[s+i], wl_spk[s+i], i);
        end
      end
      n_cmp++;
      if (wl_cyc[s+N-1] - wl_cyc[s] != 3 * (N - 1)) begin
        n_bad++; $display("FAIL sweep_span: got %0d want %0d", wl_cyc[s+N-1] - wl_cyc[s], 3 * (N - 1));
      end
      n_cmp++;
      if (done_cyc.size() - d0 != 1) begin
        n_bad++; $display("FAIL sweep_done_cnt: got %0d want 1", done_cyc.size() - d0);
      end else if (done_cyc[d0] != wl_cyc[s+N-1] + 1) begin
        n_bad++; $display("FAIL sweep_done_time: got %0d want %0d", done_cyc[d0], wl_cyc[s+N-1] + 1);
      end
    end
    for (int a = 0; a < N; a++) begin
      n_cmp++;
      if (mem[a] !== upd(init[a], 1)) begin n_bad++; $display("FAIL sweep_mem%0d: got %h want %h", a, mem[a], upd(init[a], 1)); end
    end
    n_cmp++;
    if ({busy, sweep_overrun} !== 2'b00) begin n_bad++; $display("FAIL sweep_end: busy/ovr %b want 00", {busy, sweep_overrun}); end
  endtask

  task automatic test_sweep_with_spike();
    int exp_order[5] = '{0, 1, 9, 2, 3};
    int s, d0;
    bit found = 0, got = 0;
    s = wl_addr.size(); d0 = done_cyc.size();
    param_ca_en = 1'b1;
    pulse_sweep();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (sram_cs && sram_we && sram_addr == 8'd0) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL mix_start: write to addr 0 got none want one"); end
    tick();                                          // sweep op at ptr 1 now in READ
    spk_addr = 8'd9; spk_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (spk_ack) got = 1;
    end
    spk_req = 1'b0;
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL mix_ack: spk_ack got none want one"); end
    repeat (20) tick();
    n_cmp++;
    if (wl_addr.size() - s != 5) begin
      n_bad++; $display("FAIL mix_nwrites: got %0d want 5", wl_addr.size() - s);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (wl_addr[s+i] != exp_order[i] || wl_spk[s+i] != (i == 2 ? 1 : 0)) begin
          n_bad++; $display("FAIL mix_order%0d: addr %0d spk %0d want addr %0d spk %0d",
                            i, wl_addr[s+i], wl_spk[s+i], exp_order[i], (i == 2 ? 1 : 0));
        end
      end
    end
    n_cmp++;
    if (done_cyc.size() - d0 != 1) begin n_bad++; $display("FAIL mix_done: got %0d want 1", done_cyc.size() - d0); end
  endtask

  task automatic test_overrun();
    int s, d0;
    s = wl_addr.size(); d0 = done_cyc.size();
    param_ca_en = 1'b1;
    pulse_sweep();
    repeat (4) tick();
    pulse_sweep();
    n_cmp++;
    if (sweep_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", sweep_overrun); end
    repeat (40) tick();
    n_cmp++;
    if (sweep_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", sweep_overrun); end
    n_cmp++;
    if (wl_addr.size() - s != N || done_cyc.size() - d0 != 1) begin
      n_bad++; $display("FAIL ovr_dropped: writes %0d dones %0d want %0d 1", wl_addr.size() - s, done_cyc.size() - d0, N);
    end
  endtask

  task automatic test_ca_disabled();
    int ac0, busy_hits = 0, lat = -1, t0;
    logic [7:0] w;
    param_ca_en = 1'b0;
    tick();
    ac0 = access_cnt;
    pulse_sweep();
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0) busy_hits++;
      tick();
    end
    n_cmp++;
    if (busy_hits != 0) begin n_bad++; $display("FAIL noca_busy: busy cycles %0d want 0", busy_hits); end
    n_cmp++;
    if (access_cnt != ac0) begin n_bad++; $display("FAIL noca_sram: accesses %0d want 0", access_cnt - ac0); end
    w = 8'($urandom);
    load(3, w);
    spk_addr = 8'd3; spk_req = 1'b1; t0 = cyc;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      tick();
      if (spk_ack) lat = cyc - t0;
    end
    spk_req = 1'b0;
    tick();
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL noca_spk_lat: got %0d want 3", lat); end
    n_cmp++;
    if (mem[3] !== upd(w, 1)) begin n_bad++; $display("FAIL noca_spk_mem: got %h want %h", mem[3], upd(w, 1)); end
    param_ca_en = 1'b1;
  endtask

  task automatic test_random_mix();
    logic [7:0] init [16];
    int spk_n [16];
    int exp_spk[$];
    int s, sw_iss = 0, sw_done = 0, req_cyc = 0, lat_bad = 0, bad_flag = 0;
    int sp_seen = 0, sw_seen = 0, sp_bad = 0, sw_bad = 0;
    bit fin = 0;
    for (int a = 0; a < 16; a++) begin init[a] = 8'($urandom); spk_n[a] = 0; load(a, init[a]); end
    s = wl_addr.size();
    param_ca_en = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      tick();
      if (sweep_done) sw_done++;
      if (sweep_req) sweep_req = 1'b0;
      else if (sw_done == sw_iss && sw_iss < 3 && $urandom_range(0, 3) == 0) begin
        sweep_req = 1'b1; sw_iss++;
      end
      if (spk_req) begin
        if (spk_ack) begin
          if (cyc - req_cyc < 3 || cyc - req_cyc > 6) begin
            lat_bad++; $display("FAIL rnd_spk_lat: got %0d want 3..6", cyc - req_cyc);
          end
          spk_req = 1'b0;
        end
      end else if (sw_done < 3 && $urandom_range(0, 2) == 0) begin
        spk_addr = 8'($urandom_range(0, 15));
        exp_spk.push_back(int'(spk_addr));
        spk_n[spk_addr]++;
        spk_req = 1'b1; req_cyc = cyc;
      end
      if (sw_done == 3 && !spk_req && !sweep_req) fin = 1;
    end
    spk_req = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL rnd_timeout: sweeps done %0d want 3", sw_done); end
    n_cmp++;
    if (lat_bad != 0) begin n_bad++; $display("FAIL rnd_latency: out-of-range acks %0d want 0", lat_bad); end
    for (int i = s; i < wl_addr.size(); i++) begin
      if (wl_spk[i] + wl_tref[i] != 1) bad_flag++;
      if (wl_spk[i] == 1) begin
        if (sp_seen >= exp_spk.size() || wl_addr[i] != exp_spk[sp_seen]) sp_bad++;
        sp_seen++;
      end else begin
        if (wl_addr[i] != sw_seen % N) sw_bad++;
        sw_seen++;
      end
    end
    n_cmp++;
    if (bad_flag != 0) begin n_bad++; $display("FAIL rnd_strobes: bad writes %0d want 0", bad_flag); end
    n_cmp++;
    if (sp_seen != exp_spk.size() || sp_bad != 0) begin
      n_bad++; $display("FAIL rnd_spk_order: ops %0d wrong %0d want %0d 0", sp_seen, sp_bad, exp_spk.size());
    end
    n_cmp++;
    if (sw_seen != 3 * N || sw_bad != 0) begin
      n_bad++; $display("FAIL rnd_sweep_order: ops %0d wrong %0d want %0d 0", sw_seen, sw_bad, 3 * N);
    end
    for (int a = 0; a < 16; a++) begin
      n_cmp++;
      if (mem[a] !== upd(init[a], spk_n[a] + (a < N ? 3 : 0))) begin
        n_bad++; $display("FAIL rnd_mem%0d: got %h want %h", a, mem[a], upd(init[a], spk_n[a] + (a < N ? 3 : 0)));
      end
    end
  endtask

  task automatic test_reset_mid_latch();
    int s, ac0, busy_hits = 0;
    bit found = 0;
    param_ca_en = 1'b1;
    pulse_sweep();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (sram_cs && !sram_we) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL rst_read: READ got none want one"); end
    tick();                                          // LATCH
    s = wl_addr.size();
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== 32'h0) begin n_bad++; $display("FAIL rst_async: got %h want 00000000", all_outs); end
    tick(); tick();
    RST = 1'b1;
    ac0 = access_cnt;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b0) busy_hits++;
    end
    n_cmp++;
    if (busy_hits != 0 || access_cnt != ac0) begin
      n_bad++; $display("FAIL rst_resume: busy cycles %0d accesses %0d want 0 0", busy_hits, access_cnt - ac0);
    end
    n_cmp++;
    if (wl_addr.size() != s) begin n_bad++; $display("FAIL rst_nowrite: writes %0d want 0", wl_addr.size() - s); end
  endtask

  initial begin
    test_reset();
    test_spike_latency();
    test_sweep();
    test_sweep_with_spike();
    test_overrun();
    test_ca_disabled();
    test_random_mix();
    test_reset_mid_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run got no end want end");
    $fatal(1, "watchdog");
  end

endmodule
